// File: rtl/multibyte_adder_seq.sv
// WORDS x 8-bit add/subtract sequencer: one shared 8-bit full-adder slice processes
// one byte per cycle, LSB first, with the carry held in a register between bytes.
module multibyte_adder_seq #(
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*WORDS-1:0] op_a,
   input  logic [8*WORDS-1:0] op_b,
   input  logic               cin,
   input  logic               sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*WORDS-1:0] result,
   output logic               cout,
   output logic               ovf,
   output logic               busy
);

   localparam int W     = 8 * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [W-1:0]       a_reg;
   logic [W-1:0]       b_reg;
   logic [W-1:0]       res_reg;
   logic               sub_reg;
   logic               carry;
   logic               cout_reg;
   logic               ovf_reg;
   logic [IDX_W-1:0]   idx;
   logic [7:0]         a_byte;
   logic [7:0]         b_sel;
   logic [7:0]         b_byte;
   logic [8:0]         sum;
   logic [7:0]         low_sum;
   logic               c_msb;
   logic               last;
   logic               accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = in_valid && (state == IDLE);
   assign last   = (idx == IDX_W'(WORDS - 1));

   // Byte lane selection and the single shared 8-bit adder slice
   always_comb begin
      a_byte = 8'd0;
      b_sel  = 8'd0;
      for (int i = 0; i < WORDS; i++) begin
         if (idx == IDX_W'(i)) begin
            a_byte = a_reg[i*8 +: 8];
            b_sel  = b_reg[i*8 +: 8];
         end
      end
      b_byte  = sub_reg ? ~b_sel : b_sel;
      sum     = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry};
      low_sum = {1'b0, a_byte[6:0]} + {1'b0, b_byte[6:0]} + {7'd0, carry};
      c_msb   = low_sum[7];
   end

   // Operands need no reset: they are only consumed after a capture
   always_ff @(posedge clk) begin
      if (accept) begin
         a_reg <= op_a;
         b_reg <= op_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_reg  <= '0;
         sub_reg  <= 1'b0;
         carry    <= 1'b0;
         cout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
         idx      <= '0;
      end else if (accept) begin
         sub_reg <= sub;
         carry   <= sub | cin;
         idx     <= '0;
      end else if (state == RUN) begin
         for (int i = 0; i < WORDS; i++) begin
            if (idx == IDX_W'(i)) res_reg[i*8 +: 8] <= sum[7:0];
         end
         carry <= sum[8];
         if (last) begin
            cout_reg <= sum[8];
            ovf_reg  <= c_msb ^ sum[8];
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

   assign result = res_reg;
   assign cout   = cout_reg;
   assign ovf    = ovf_reg;

endmodule

// File: tb/tb_multibyte_adder_seq.sv
// Bench for multibyte_adder_seq: directed table on WORDS=4 plus a queue scoreboard
// that checks WORDS=1, 4 and 16 instances sharing one stimulus bus.
module tb_multibyte_adder_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, in_valid, out_ready, cin, sub;
   logic [127:0] op_a, op_b;

   logic ir4, ov4, co4, of4, bz4;
   logic ir1, ov1, co1, of1, bz1;
   logic ir16, ov16, co16, of16, bz16;
   logic [31:0]  r4;
   logic [7:0]   r1;
   logic [127:0] r16;

   multibyte_adder_seq #(.WORDS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
      .op_a(op_a[31:0]), .op_b(op_b[31:0]), .cin(cin), .sub(sub),
      .out_valid(ov4), .out_ready(out_ready), .result(r4), .cout(co4), .ovf(of4), .busy(bz4));

   multibyte_adder_seq #(.WORDS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
      .op_a(op_a[7:0]), .op_b(op_b[7:0]), .cin(cin), .sub(sub),
      .out_valid(ov1), .out_ready(out_ready), .result(r1), .cout(co1), .ovf(of1), .busy(bz1));

   multibyte_adder_seq #(.WORDS(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
      .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
      .out_valid(ov16), .out_ready(out_ready), .result(r16), .cout(co16), .ovf(of16), .busy(bz16));

   typedef struct {
      logic [127:0] res;
      logic         cout;
      logic         ovf;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        ci;
      logic        s;
      logic [31:0] r;
      logic        co;
      logic        of;
   } vec_t;

   exp_t q[3][$];
   vec_t tbl[7];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   stream_mode = 1'b0;
   int   prev[3];
   int   nhs[3];

   always @(posedge clk) cyc <= cyc + 1;

   // Bit-serial ripple reference: returns {ovf, cout, result}
   function automatic logic [129:0] model(input int w, input logic [127:0] a, input logic [127:0] b,
                                          input logic ci, input logic s);
      logic [127:0] r;
      logic         c, bb, cm;
      r  = '0;
      c  = s ? 1'b1 : ci;
      cm = 1'b0;
      for (int i = 0; i < 8*w; i++) begin
         bb = s ? ~b[i] : b[i];
         if (i == 8*w-1) cm = c;
         r[i] = a[i] ^ bb ^ c;
         c    = (a[i] & bb) | (a[i] & c) | (bb & c);
      end
      return {cm ^ c, c, r};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic mon(input int k, input int w, input logic ir, input logic ov,
                      input logic [127:0] res, input logic co, input logic of);
      logic [129:0] m;
      exp_t         e;
      if (!rst_n) begin
         q[k].delete();
      end else begin
         if (ov && out_ready) begin
            if (q[k].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb%0d_unexpected: got result %0h expected no output", w, res);
            end else begin
               e = q[k].pop_front();
               chk($sformatf("sb%0d_result", w), res, e.res);
               chk1($sformatf("sb%0d_cout", w), co, e.cout);
               chk1($sformatf("sb%0d_ovf", w), of, e.ovf);
               if (stream_mode) begin
                  if (prev[k] >= 0) chk($sformatf("sb%0d_interval", w), 128'(cyc - prev[k]), 128'(w + 2));
                  prev[k] = cyc;
                  nhs[k]++;
               end
            end
         end
         if (in_valid && ir) begin
            m     = model(w, op_a, op_b, cin, sub);
            e.res = m[127:0];
            e.cout = m[128];
            e.ovf  = m[129];
            q[k].push_back(e);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, 4, ir4, ov4, 128'(r4), co4, of4);
      mon(1, 1, ir1, ov1, 128'(r1), co1, of1);
      mon(2, 16, ir16, ov16, r16, co16, of16);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(ir4 && ir1 && ir16) && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: got busy after %0d cycles required idle", n);
      end
   endtask

   task automatic issue(input logic [127:0] a, input logic [127:0] b, input logic ci, input logic s);
      op_a = a;
      op_b = b;
      cin  = ci;
      sub  = s;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_out4(output int lat);
      lat = 0;
      while (!ov4 && lat < 50) begin
         step();
         lat++;
      end
   endtask

   task automatic apply_row(input int i, input vec_t v);
      int lat;
      wait_idle();
      issue(128'(v.a), 128'(v.b), v.ci, v.s);
      chk1($sformatf("row%0d_busy", i), bz4, 1'b1);
      chk1($sformatf("row%0d_in_ready", i), ir4, 1'b0);
      wait_out4(lat);
      chk($sformatf("row%0d_latency", i), 128'(lat), 128'(4));
      chk($sformatf("row%0d_result", i), 128'(r4), 128'(v.r));
      chk1($sformatf("row%0d_cout", i), co4, v.co);
      chk1($sformatf("row%0d_ovf", i), of4, v.of);
   endtask

   task automatic chk_reset(input string tag);
      chk1({tag, "_in_ready"}, ir4, 1'b1);
      chk1({tag, "_out_valid"}, ov4, 1'b0);
      chk1({tag, "_busy"}, bz4, 1'b0);
      chk({tag, "_result"}, 128'(r4), 128'(0));
      chk1({tag, "_cout"}, co4, 1'b0);
      chk1({tag, "_ovf"}, of4, 1'b0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n;
      tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
      tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
      tbl[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
      tbl[3] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
      tbl[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
      tbl[5] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
      tbl[6] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
      op_a = '0; op_b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("por");
      rst_n = 1'b1;
      step();
      chk_reset("post_por");

      for (int i = 0; i < 6; i++) apply_row(i, tbl[i]);

      // Backpressure: result held, new operands ignored while DONE
      wait_idle();
      out_ready = 1'b0;
      issue(128'h01020304, 128'h10203040, 1'b0, 1'b0);
      wait_out4(lat);
      chk("bp_latency", 128'(lat), 128'(4));
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         op_a = {$urandom(), $urandom(), $urandom(), $urandom()};
         op_b = {$urandom(), $urandom(), $urandom(), $urandom()};
         step();
         chk("bp_result", 128'(r4), 128'h11223344);
         chk1("bp_in_ready", ir4, 1'b0);
         chk1("bp_out_valid", ov4, 1'b1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk1("bp_release_out_valid", ov4, 1'b0);
      chk1("bp_release_in_ready", ir4, 1'b1);

      // Reset after two bytes have been processed
      wait_idle();
      issue(128'hAAAAAAAA, 128'h55555555, 1'b0, 1'b0);
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk_reset("mid_run");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply_row(6, tbl[6]);

      // Streaming with in_valid and out_ready held high
      wait_idle();
      stream_mode = 1'b1;
      for (int k = 0; k < 3; k++) begin
         prev[k] = -1;
         nhs[k]  = 0;
      end
      n = 0;
      while (nhs[2] < 8 && n < 400) begin
         op_a = {$urandom(), $urandom(), $urandom(), $urandom()};
         op_b = {$urandom(), $urandom(), $urandom(), $urandom()};
         cin  = 1'($urandom_range(0, 1));
         sub  = 1'($urandom_range(0, 1));
         in_valid  = 1'b1;
         out_ready = 1'b1;
         step();
         n++;
      end
      in_valid = 1'b0;
      stream_mode = 1'b0;
      chk1("stream_w16_count", nhs[2] >= 8, 1'b1);
      chk1("stream_w4_count", nhs[0] >= 8, 1'b1);
      chk1("stream_w1_count", nhs[1] >= 8, 1'b1);

      repeat (40) step();
      chk("drain_q4", 128'(q[0].size()), 128'(0));
      chk("drain_q1", 128'(q[1].size()), 128'(0));
      chk("drain_q16", 128'(q[2].size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multibyte_adder_seq.md
# multibyte_adder_seq

Sequencer that performs WORDS×8-bit add/subtract by reusing a single 8-bit ripple-carry full-adder datapath, one byte per cycle, LSB first, with the carry chained through a register between bytes. It sits between a valid/ready operand producer and a valid/ready result consumer. It lets wide arithmetic share the existing 8-bit adder slice instead of instantiating a wide adder.

## Interface
Parameters:
- WORDS, 4, number of byte lanes; operand width is 8*WORDS; legal range 1..16.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block accepts operands; high only in IDLE.
- op_a  input  8*WORDS  operand A.
- op_b  input  8*WORDS  operand B.
- cin  input  1  carry-in for add.
- sub  input  1  1 = compute A − B; 0 = compute A + B + cin.
- out_valid  output  1  result, cout and ovf are valid.
- out_ready  input  1  consumer accepts result.
- result  output  8*WORDS  sum/difference, modulo 2^(8*WORDS).
- cout  output  1  final carry out; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).
- busy  output  1  high in RUN and DONE.

## Operation
- Fixed decision: one clock; reset is asynchronous and active-low.
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture op_a, op_b, sub, then go to RUN with byte index 0 and carry register = sub ? 1 : cin. When sub=1, cin is ignored.
- Operand capture: after acceptance, port changes have no effect on the operation in flight.
- RUN: each cycle, byte i = a[i] + (sub ? ~b[i] : b[i]) + carry, through one 8-bit full-adder slice.
  - Write byte i of the working result register and update the carry register.
  - On the last byte (i = WORDS−1), latch cout and ovf and go to DONE. Otherwise i increments.
- DONE: out_valid=1; result, cout and ovf are held stable. On out_valid&&out_ready, go to IDLE.
- in_valid outside IDLE is ignored, not queued. No bypass: acceptance and output handshake never occur in the same cycle.
- result is driven from the working register. Its contents are defined only while out_valid=1, except after reset, when it is 0.
- Reset while in any state: immediately return to IDLE and discard the operation in flight.
- WORDS=1: RUN lasts exactly one cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, cout=0, ovf=0.
- Acceptance at edge k: busy and in_ready change after edge k.
- Bytes 0..WORDS−1 are processed at edges k+1..k+WORDS.
- out_valid rises after edge k+WORDS (latency = WORDS cycles from the accepting edge).
- Output handshake at edge m: out_valid falls and in_ready rises after edge m; the earliest next acceptance is at edge m+1.
- Throughput with out_ready tied high: one operation per WORDS+2 cycles.
- out_valid stays high, with result/cout/ovf stable, for as long as out_ready is low.

## Test plan
- Byte-boundary carry: WORDS=4, add A=0x000000FF, B=0x00000001, cin=0 → result 0x00000100, cout=0, ovf=0; out_valid exactly 4 cycles after acceptance.
- Full carry ripple: add A=0xFFFFFFFF, B=0x00000000, cin=1 → result 0x00000000, cout=1, ovf=0.
- Subtract:
  - A=5, B=7, sub=1 → 0xFFFFFFFE, cout=0, ovf=0.
  - A=0x80000000, B=1, sub=1 with cin=1 (must be ignored) → 0x7FFFFFFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands → result stable, in_ready=0, new operands ignored. Raise out_ready → in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst_n=0 after 2 bytes processed → all outputs at reset values immediately. A following op A=0x12345678 + B=0x11111111 → 0x23456789, cout=0.
- Streaming: in_valid and out_ready held high, 8 random ops, checked against a reference model → one result per WORDS+2 cycles; repeat with WORDS=1 and WORDS=16.
